// File: rtl/jitdom_btb_pkg.sv
// Shared types and helpers for the domain-tagged BTB.
// Macro JITDOM_BTB_DOMCHECK_EN adds a source-domain field to each entry.
package jitdom_btb_pkg;

    localparam int unsigned VLEN           = 39;
    localparam int unsigned DOM_BITS       = 2;
    localparam int unsigned BTB_NR_ENTRIES = 32;
    localparam int unsigned BTB_TAG_BITS   = 12;
    localparam int unsigned BTB_IDX_LSB    = 1;

    typedef logic [DOM_BITS-1:0] dmp_domain_t;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        cf_t             cf_type;
        dmp_domain_t     expdom;
    } bp_resolve_t;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [VLEN-1:0]         target;
        dmp_domain_t             expdom;
`ifdef JITDOM_BTB_DOMCHECK_EN
        dmp_domain_t             srcdom;
`endif
    } jitdom_btb_entry_t;

    function automatic logic op_is_regjump(input cf_t cf);
        return cf == JumpR;
    endfunction

    // A resolution trains the BTB only for a mispredicted register jump outside debug/flush.
    function automatic logic btb_upd_qualify(input bp_resolve_t res, input logic debug_mode,
                                             input logic flush);
        return res.valid && res.is_mispredict && op_is_regjump(res.cf_type)
               && !debug_mode && !flush;
    endfunction

    function automatic int unsigned btb_index(input logic [VLEN-1:0] vpc,
                                              input int unsigned idx_lsb,
                                              input int unsigned nr_entries);
        return 32'(vpc >> idx_lsb) & (nr_entries - 32'd1);
    endfunction

    function automatic logic [BTB_TAG_BITS-1:0] btb_tag(input logic [VLEN-1:0] vpc,
                                                        input int unsigned tag_lsb,
                                                        input int unsigned tag_bits);
        logic [63:0] mask;
        mask = (64'd1 << tag_bits) - 64'd1;
        return BTB_TAG_BITS'(64'(vpc >> tag_lsb) & mask);
    endfunction

endpackage

// File: rtl/jitdom_btb.sv
// Direct-mapped BTB predicting register-jump targets and their expected domain.
// Macro JITDOM_BTB_DOMCHECK_EN adds curdom_i and a source-domain match on hit.
module jitdom_btb
    import jitdom_btb_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = BTB_NR_ENTRIES,
    parameter int unsigned TAG_BITS   = BTB_TAG_BITS,
    parameter int unsigned IDX_LSB    = BTB_IDX_LSB
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] vpc_i,
    input  bp_resolve_t     resolved_branch_i,
`ifdef JITDOM_BTB_DOMCHECK_EN
    input  dmp_domain_t     curdom_i,
`endif
    output logic            pred_valid_o,
    output logic [VLEN-1:0] pred_target_o,
    output dmp_domain_t     pred_expdom_o
);

    localparam int unsigned IDX_W   = $clog2(NR_ENTRIES);
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

    typedef struct packed {
        logic                    valid;
        logic [IDX_W-1:0]        idx;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [VLEN-1:0]         target;
        dmp_domain_t             expdom;
`ifdef JITDOM_BTB_DOMCHECK_EN
        dmp_domain_t             srcdom;
`endif
    } upd_t;

    jitdom_btb_entry_t [NR_ENTRIES-1:0] arr_q;
    upd_t                               upd_q;
    upd_t                               upd_d;
    jitdom_btb_entry_t                  wr_entry;
    jitdom_btb_entry_t                  lk_entry;
    logic [IDX_W-1:0]                   lk_idx;
    logic [BTB_TAG_BITS-1:0]            lk_tag;
    logic                               hit;

    // Stage-1 capture of a qualifying resolution; bit 0 of the target is dropped here.
    always_comb begin
        upd_d        = '0;
        upd_d.valid  = btb_upd_qualify(resolved_branch_i, debug_mode_i, flush_i);
        upd_d.idx    = IDX_W'(btb_index(resolved_branch_i.pc, IDX_LSB, NR_ENTRIES));
        upd_d.tag    = btb_tag(resolved_branch_i.pc, TAG_LSB, TAG_BITS);
        upd_d.target = resolved_branch_i.target_address & ~VLEN'(1);
        upd_d.expdom = resolved_branch_i.expdom;
`ifdef JITDOM_BTB_DOMCHECK_EN
        upd_d.srcdom = curdom_i;
`endif
    end

    always_comb begin
        wr_entry        = '0;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = upd_q.tag;
        wr_entry.target = upd_q.target;
        wr_entry.expdom = upd_q.expdom;
`ifdef JITDOM_BTB_DOMCHECK_EN
        wr_entry.srcdom = upd_q.srcdom;
`endif
    end

    // Lookup with write-first forwarding from the pending update.
    always_comb begin
        lk_idx   = IDX_W'(btb_index(vpc_i, IDX_LSB, NR_ENTRIES));
        lk_tag   = btb_tag(vpc_i, TAG_LSB, TAG_BITS);
        lk_entry = arr_q[lk_idx];
        if (upd_q.valid && (upd_q.idx == lk_idx)) begin
            lk_entry = wr_entry;
        end
        hit = lk_entry.valid && (lk_entry.tag == lk_tag) && !flush_i;
`ifdef JITDOM_BTB_DOMCHECK_EN
        if (lk_entry.srcdom != curdom_i) begin
            hit = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arr_q <= '0;
            upd_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                arr_q[i].valid <= 1'b0;
            end
            upd_q.valid <= 1'b0;
        end else begin
            if (upd_q.valid) begin
                arr_q[upd_q.idx] <= wr_entry;
            end
            upd_q <= upd_d;
        end
    end

    // Prediction register; target/expdom hold while no lookup is presented.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_valid_o  <= 1'b0;
            pred_target_o <= '0;
            pred_expdom_o <= '0;
        end else begin
            pred_valid_o <= lookup_valid_i && hit;
            if (lookup_valid_i) begin
                pred_target_o <= lk_entry.target;
                pred_expdom_o <= lk_entry.expdom;
            end
        end
    end

endmodule
